// File: rtl/fourbit_rr_arbiter.sv
// Round-robin arbiter for a shared 4-bit, 4-input data path.
// Grants one requester at a time and steers its word onto a valid/ready
// output. Each grant holds for up to MAX_BURST transfers while others wait.
// A grant with no competitor continues indefinitely. The registered sel
// drives the downstream 4:1 mux.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; waiting for any req bit
// GRANT | requester sel owns the path; transfers on out_valid & out_ready

module fourbit_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic [3:0] i2,
    input  logic [3:0] i3,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] y,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic [3:0] ack
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sel_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [3:0]    grant_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          xfer;
    logic [3:0]    req_next;
    logic          others;
    logic          rel;

    // First requester at or after index p, wrapping; p when r is empty.
    function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] k;
        logic [1:0] res;
        res = p;
        for (int n = 3; n >= 0; n--) begin
            k = p + 2'(n);
            if (r[k]) res = k;
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Steer the selected word onto y.
    always_comb begin
        case (sel)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            default: y = i3;
        endcase
    end

    // Handshake outputs; grant is already zero in IDLE so ack stays quiet.
    always_comb begin
        out_valid = (state == GRANT) && req[sel];
        xfer      = out_valid && out_ready;
        ack       = grant & {4{xfer}};
    end

    // Next-state: arbitration, burst counting and release handling.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        rel       = 1'b0;
        req_next  = req & ~grant;
        others    = |req_next;
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_nxt   = arb(req, ptr);
                    grant_nxt = onehot(sel_nxt);
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    // Alone on the bus the count saturates so a late
                    // competitor only waits one more transfer.
                    if (others && (cnt == CNT_LAST)) begin
                        rel = 1'b1;
                    end else if (cnt != CNT_LAST) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                if (rel) begin
                    ptr_nxt = sel + 2'd1;
                    if (others) begin
                        sel_nxt   = arb(req_next, sel + 2'd1);
                        grant_nxt = onehot(sel_nxt);
                        cnt_nxt   = '0;
                    end else begin
                        grant_nxt = 4'b0000;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    // State registers; reset drops any in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            grant <= 4'b0000;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fourbit_rr_arbiter.sv
// Bench for fourbit_rr_arbiter: two instances (MAX_BURST=4 and 1) share
// stimulus; a per-instance owner/credit model is compared every cycle,
// and directed steps carry literal expectations.

module tb_fourbit_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic       out_ready;

    logic       ov_d    [2];
    logic [3:0] y_d     [2];
    logic [1:0] sel_d   [2];
    logic [3:0] grant_d [2];
    logic [3:0] ack_d   [2];

    int ntests = 0;
    int nfail  = 0;

    fourbit_rr_arbiter #(.MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .out_ready(out_ready), .out_valid(ov_d[0]), .y(y_d[0]),
        .sel(sel_d[0]), .grant(grant_d[0]), .ack(ack_d[0])
    );

    fourbit_rr_arbiter #(.MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .out_ready(out_ready), .out_valid(ov_d[1]), .y(y_d[1]),
        .sel(sel_d[1]), .grant(grant_d[1]), .ack(ack_d[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 idle), transfers in current grant,
    // rotation pointer and last mux select.
    int mb    [2] = '{4, 1};
    int owner [2];
    int mcnt  [2];
    int mptr  [2];
    int msel  [2];

    function automatic int pick(input logic [3:0] r, input int from);
        for (int n = 0; n < 4; n++)
            if (r[(from + n) % 4]) return (from + n) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] word(input int k);
        case (k)
            0:       return i0;
            1:       return i1;
            2:       return i2;
            default: return i3;
        endcase
    endfunction

    task automatic model_step(input int j);
        logic [3:0] rest;
        bit         rel;
        rel = 0;
        if (owner[j] < 0) begin
            if (req != 4'b0) begin
                owner[j] = pick(req, mptr[j]);
                msel[j]  = owner[j];
                mcnt[j]  = 0;
            end
        end else begin
            rest = req & ~(4'b0001 << owner[j]);
            if (!req[owner[j]]) begin
                rel = 1;
            end else if (out_ready) begin
                if (rest != 4'b0 && mcnt[j] + 1 >= mb[j]) rel = 1;
                else mcnt[j] = (mcnt[j] + 1 > mb[j] - 1) ? mb[j] - 1 : mcnt[j] + 1;
            end
            if (rel) begin
                mptr[j] = (owner[j] + 1) % 4;
                if (rest != 4'b0) begin
                    owner[j] = pick(rest, mptr[j]);
                    msel[j]  = owner[j];
                    mcnt[j]  = 0;
                end else begin
                    owner[j] = -1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                owner[j] = -1; mcnt[j] = 0; mptr[j] = 0; msel[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) model_step(j);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic [3:0] eg, ea, ey;
            logic [1:0] es;
            logic       ev;
            if (owner[j] < 0) begin
                eg = 4'b0; ea = 4'b0; ev = 1'b0;
                es = 2'(msel[j]); ey = word(msel[j]);
            end else begin
                eg = 4'b0001 << owner[j];
                es = 2'(owner[j]);
                ev = req[owner[j]];
                ea = (ev && out_ready) ? eg : 4'b0;
                ey = word(owner[j]);
            end
            chk($sformatf("mdl_grant[%0d]", j), 32'(grant_d[j]), 32'(eg));
            chk($sformatf("mdl_sel[%0d]",   j), 32'(sel_d[j]),   32'(es));
            chk($sformatf("mdl_valid[%0d]", j), 32'(ov_d[j]),    32'(ev));
            chk($sformatf("mdl_ack[%0d]",   j), 32'(ack_d[j]),   32'(ea));
            chk($sformatf("mdl_y[%0d]",     j), 32'(y_d[j]),     32'(ey));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0; req = 4'b0; out_ready = 1'b0;
        i0 = 4'h0; i1 = 4'h0; i2 = 4'h0; i3 = 4'h0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; out_ready = 1'b0;
        i0 = 4'h0; i1 = 4'h0; i2 = 4'h0; i3 = 4'h0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("rst_grant", 32'(grant_d[j]), 32'h0);
            chk("rst_sel",   32'(sel_d[j]),   32'h0);
            chk("rst_valid", 32'(ov_d[j]),    32'h0);
            chk("rst_ack",   32'(ack_d[j]),   32'h0);
            chk("rst_y",     32'(y_d[j]),     32'h0);
        end

        // T1: first grant one edge after req is seen
        cyc();
        rst_n = 1'b1; req = 4'b0001; i0 = 4'hA; out_ready = 1'b1;
        #1 chk("t1_idle_valid", 32'(ov_d[0]), 32'h0);
        cyc();
        #1;
        chk("t1_grant", 32'(grant_d[0]), 32'h1);
        chk("t1_sel",   32'(sel_d[0]),   32'h0);
        chk("t1_valid", 32'(ov_d[0]),    32'h1);
        chk("t1_y",     32'(y_d[0]),     32'hA);
        chk("t1_ack",   32'(ack_d[0]),   32'h1);
        chk("t1_grant_mb1", 32'(grant_d[1]), 32'h1);
        cyc();
        req = 4'b0000;
        #1 chk("t1_drop_ack", 32'(ack_d[0]), 32'h0);
        cyc();
        #1 chk("t1_idle_grant", 32'(grant_d[0]), 32'h0);

        // T2: MAX_BURST=1 rotates every transfer with no bubble
        do_reset();
        req = 4'b1111; i0 = 4'h1; i1 = 4'h2; i2 = 4'h3; i3 = 4'h4; out_ready = 1'b1;
        #1 chk("t2_idle_grant", 32'(grant_d[1]), 32'h0);
        for (int n = 0; n < 5; n++) begin
            cyc();
            #1;
            chk($sformatf("t2_grant%0d", n), 32'(grant_d[1]), 32'(4'b0001 << (n % 4)));
            chk($sformatf("t2_ack%0d", n),   32'(ack_d[1]),   32'(4'b0001 << (n % 4)));
            chk($sformatf("t2_y%0d", n),     32'(y_d[1]),     32'((n % 4) + 1));
        end
        cyc(); req = 4'b0000;
        cyc(); cyc();

        // T3: MAX_BURST=4 gives bursts of four
        do_reset();
        req = 4'b0011; i0 = 4'h7; i1 = 4'h9; out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc();
            #1;
            chk($sformatf("t3_grant%0d", n), 32'(grant_d[0]), 32'(4'b0001 << ((n / 4) % 2)));
            chk($sformatf("t3_ack%0d", n),   32'(ack_d[0]),   32'(4'b0001 << ((n / 4) % 2)));
        end
        cyc(); req = 4'b0000;
        cyc(); cyc();

        // T4: backpressure holds the word, then a single ack
        do_reset();
        req = 4'b0100; i2 = 4'h5; out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cyc();
            #1;
            chk("t4_grant", 32'(grant_d[0]), 32'h4);
            chk("t4_valid", 32'(ov_d[0]),    32'h1);
            chk("t4_y",     32'(y_d[0]),     32'h5);
            chk("t4_ack",   32'(ack_d[0]),   32'h0);
        end
        cyc();
        out_ready = 1'b1;
        #1 chk("t4_ack_go", 32'(ack_d[0]), 32'h4);
        cyc();
        req = 4'b0000;
        #1 chk("t4_ack_after", 32'(ack_d[0]), 32'h0);
        cyc();

        // T5: withdrawal releases without ack and advances the pointer
        do_reset();
        req = 4'b0100; i0 = 4'h1; i3 = 4'h8; out_ready = 1'b0;
        cyc();
        #1 chk("t5_grant2", 32'(grant_d[0]), 32'h4);
        cyc();
        req = 4'b1001;
        #1;
        chk("t5_wd_valid", 32'(ov_d[0]),  32'h0);
        chk("t5_wd_ack",   32'(ack_d[0]), 32'h0);
        cyc();
        #1;
        chk("t5_grant3", 32'(grant_d[0]), 32'h8);
        chk("t5_sel3",   32'(sel_d[0]),   32'h3);
        chk("t5_y3",     32'(y_d[0]),     32'h8);
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) cyc();
        req = 4'b0000;
        cyc(); cyc();

        // T6: asynchronous reset mid-burst, restart from ptr 0
        do_reset();
        req = 4'b0011; i1 = 4'h3; i2 = 4'h6; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        #1 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("t6_rst_grant", 32'(grant_d[j]), 32'h0);
            chk("t6_rst_sel",   32'(sel_d[j]),   32'h0);
            chk("t6_rst_valid", 32'(ov_d[j]),    32'h0);
            chk("t6_rst_ack",   32'(ack_d[j]),   32'h0);
        end
        cyc();
        rst_n = 1'b1; req = 4'b0110;
        #1 chk("t6_idle_grant", 32'(grant_d[0]), 32'h0);
        cyc();
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("t6_grant", 32'(grant_d[j]), 32'h2);
            chk("t6_sel",   32'(sel_d[j]),   32'h1);
        end
        cyc(); req = 4'b0000;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
